cram_loader: RTL and testbench
==============================

# cram_loader

Configuration sequencer for a chain of logic elements (LEs). It accepts a configuration bitstream from a host as a stream of bytes over a valid/ready handshake and serializes it MSB-first onto the fabric's shared `config_en` / `config_data` scan chain, one bit per clock. It holds the fabric's logic reset (`fabric_nrst`) low for the whole load plus a programmable settle window, then reports completion. It sits between the bitstream source (SPI or host bridge) and the head of the LE configuration chain.

## Interface
- `NUM_LE`, 4: number of LEs in the chain.
- `LE_CFG_BITS`, 17: configuration bits per LE (16 LUT bits plus 1 mode bit).
- `WORD_W`, 8: host word width.
- `RST_CYCLES`, 2: cycles `fabric_nrst` stays low after the last bit is shifted.
- Derived: `TOTAL_BITS = NUM_LE*LE_CFG_BITS`, `CNT_W = $clog2(TOTAL_BITS+1)`.

Ports (reset is asynchronous, active-low; one clock):
- `clk`  in  1  system clock; every shift occurs on its rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a load. Ignored while `busy`=1.
- `abort`  in  1  cancels a load in progress. Has priority over `start` and over all other activity.
- `in_data`  in  WORD_W  host bitstream word, MSB first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block will accept a word this cycle.
- `config_en`  out  1  chain shift enable.
- `config_data`  out  1  serial bit to the chain head.
- `fabric_nrst`  out  1  active-low reset to the LE flops.
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load completed. Level signal; cleared by the next `start`.
- `err`  out  1  last load was aborted. Sticky; cleared by the next `start`.
- `bit_cnt`  out  CNT_W  number of bits shifted in the current or last load.

## Operation
- All outputs are registered. Reset values: every output is 0, including `fabric_nrst`, so the fabric is held in reset until configured.
- States and transitions:
  - IDLE: `busy`=0, `in_ready`=0, `config_en`=0.
    - On `start`: clear `done`, `err` and `bit_cnt`; drive `fabric_nrst`=0; go to FETCH.
  - FETCH: `busy`=1, `in_ready`=1, `config_en`=0.
    - On `in_valid && in_ready`: latch `in_data` into the shift register; load the per-word count with `min(WORD_W, TOTAL_BITS - bit_cnt)`; go to SHIFT.
  - SHIFT: `config_en`=1, `config_data`=shreg[MSB].
    - Each cycle: shift left by one, increment `bit_cnt`, decrement the word count.
    - When the word count reaches 0: go to SETTLE if `bit_cnt`=TOTAL_BITS, else go to FETCH.
  - SETTLE: `config_en`=0 and `fabric_nrst`=0 for exactly RST_CYCLES cycles, then go to DONE.
  - DONE: `fabric_nrst`=1, `done`=1, `busy`=0. Behaves like IDLE; `start` begins a reload.
- Partial final word: only its upper `TOTAL_BITS mod WORD_W` bits are shifted. The lower bits are discarded, and no further word is requested.
- `config_data` is 0 whenever `config_en`=0.
- Abort, from any busy state: go to IDLE on the next edge with `config_en`=0, `in_ready`=0, `err`=1, `done`=0. `fabric_nrst` stays 0 because the fabric holds partial configuration. `bit_cnt` freezes at its value when aborted.
- If `start` and `abort` are asserted in the same cycle while in IDLE or DONE, `abort` wins: state stays IDLE and `err`=1.
- A host that stalls (`in_valid`=0 in FETCH) holds the block in FETCH indefinitely. There is no timeout.

## Timing
- `start` sampled at edge N: `busy`=1 and `in_ready`=1 during cycle N+1.
- Word accepted at edge M: the first bit appears on `config_data` with `config_en`=1 in cycle M+1.
- A full word takes WORD_W consecutive `config_en` cycles, plus at least 1 FETCH cycle between words.
- Minimum load time with `in_valid` held high: `TOTAL_BITS + ceil(TOTAL_BITS/WORD_W) + RST_CYCLES + 1` cycles from `start` to `done`.
- `done` and `fabric_nrst` rise together on the same edge.

## Test plan
- Exclusive-OR (XOR) LUT, combinational mode (NUM_LE=1, 17 bits: 0x6996 LUT, mode=0):
  - Stimulus: words 0x34, 0xCB, 0x00 with `in_valid` held high.
  - Required: the serialized stream is 0_0110100110010110; `config_en` is high for exactly 17 cycles; `bit_cnt`=17.
  - Required: `done` rises RST_CYCLES+1 cycles after the last shift; only bit 7 of the third word is used.
  - A real LE model behind the chain returns `le_out`=^select for all 16 select values.
- Registered mode, LUT=0x0001, mode=1 (NUM_LE=1):
  - Stimulus: words 0x80, 0x00, 0x80.
  - Required: stream 1_0000000000000001; the LE output is 1 only for select=0, updating on the clock edge.
- Host stalls (NUM_LE=4, 68 bits = 9 words):
  - Stimulus: drop `in_valid` for 5 cycles between words 3 and 4.
  - Required: `config_en` stays 0 during the stall and no bits are lost.
  - Required: `bit_cnt`=68 at `done`; exactly 9 handshakes occur.
- Abort mid-load:
  - Stimulus: assert `abort` after 20 bits.
  - Required next cycle: `config_en`=0, `err`=1, `done`=0, `busy`=0, `fabric_nrst`=0, `bit_cnt`=20.
  - Then issue `start`: `err` clears and a full reload completes normally.
- Illegal and simultaneous control:
  - `start` pulsed during SHIFT is ignored: `bit_cnt` is not reset.
  - `start`+`abort` together in IDLE: the block stays idle with `err`=1.
- Asynchronous reset mid-SHIFT:
  - Stimulus: drive `nrst` low between clock edges.
  - Required: all outputs are 0 immediately (no clock needed); after release, the block stays idle until `start`.

Source files
------------

// File: rtl/cram_loader.sv
// rtl/cram_loader.sv - byte-stream to serial LE configuration chain loader
module cram_loader #(
  parameter int NUM_LE      = 4,
  parameter int LE_CFG_BITS = 17,
  parameter int WORD_W      = 8,
  parameter int RST_CYCLES  = 2,
  localparam int TOTAL_BITS = NUM_LE * LE_CFG_BITS,
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              config_en,
  output logic              config_data,
  output logic              fabric_nrst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WC_W-1:0]   wcnt;
  logic [RC_W-1:0]   rcnt;
  logic [CNT_W-1:0]  rem_bits;
  logic [WC_W-1:0]   word_bits;

  // The final word may be partial: only the bits still owed to the chain are shifted.
  always_comb begin
    rem_bits  = CNT_W'(TOTAL_BITS) - bit_cnt;
    word_bits = WC_W'(WORD_W);
    if (32'(rem_bits) < WORD_W) word_bits = WC_W'(rem_bits);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      in_ready    <= 1'b0;
      config_en   <= 1'b0;
      config_data <= 1'b0;
      fabric_nrst <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      bit_cnt     <= '0;
    end else if (abort && (busy || start)) begin
      // fabric_nrst is left alone: a partially loaded fabric must stay in reset.
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      config_en   <= 1'b0;
      config_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_FETCH;
            busy        <= 1'b1;
            in_ready    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            bit_cnt     <= '0;
            fabric_nrst <= 1'b0;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            state       <= S_SHIFT;
            in_ready    <= 1'b0;
            config_en   <= 1'b1;
            config_data <= in_data[WORD_W-1];
            shreg       <= in_data << 1;
            wcnt        <= word_bits;
          end
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          wcnt    <= wcnt - WC_W'(1);
          if (wcnt == WC_W'(1)) begin
            config_en   <= 1'b0;
            config_data <= 1'b0;
            if (bit_cnt == CNT_W'(TOTAL_BITS - 1)) begin
              state <= S_SETTLE;
              rcnt  <= RC_W'(RST_CYCLES - 1);
            end else begin
              state    <= S_FETCH;
              in_ready <= 1'b1;
            end
          end else begin
            config_data <= shreg[WORD_W-1];
            shreg       <= {shreg[WORD_W-2:0], 1'b0};
          end
        end
        S_SETTLE: begin
          if (rcnt == '0) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            fabric_nrst <= 1'b1;
          end else begin
            rcnt <= rcnt - RC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cram_loader.sv
// tb/tb_cram_loader.sv - bench for cram_loader with a one-LE and a four-LE chain
module tb_cram_loader;

  localparam int RST = 2;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] start, abort, in_valid, in_ready, config_en, config_data;
  logic [1:0] fabric_nrst, busy, done, err;
  logic [7:0] in_data [2];
  logic [4:0] bc1;
  logic [6:0] bc4;

  int checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  int en_cnt [2], last_en [2], hs_cnt [2], pushed [2];
  bit sb0 [$];
  bit sb1 [$];
  logic [7:0] wbuf [16];

  typedef struct packed {
    logic [23:0] words;
    logic [16:0] cfg;
    logic        parity;
  } vec_t;
  vec_t vt [4];

  // Behavioural LE at the end of the one-LE chain: cfg1[16] is the mode bit.
  logic [16:0] cfg1;
  logic [3:0]  sel;
  logic        q1, le_out;

  initial forever #5 clk = ~clk;

  cram_loader #(.NUM_LE(1)) u1 (
    .clk(clk), .nrst(nrst), .start(start[0]), .abort(abort[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .config_en(config_en[0]), .config_data(config_data[0]), .fabric_nrst(fabric_nrst[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .bit_cnt(bc1)
  );

  cram_loader #(.NUM_LE(4)) u4 (
    .clk(clk), .nrst(nrst), .start(start[1]), .abort(abort[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .config_en(config_en[1]), .config_data(config_data[1]), .fabric_nrst(fabric_nrst[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .bit_cnt(bc4)
  );

  always @(posedge clk) if (config_en[0]) cfg1 <= {cfg1[15:0], config_data[0]};
  always @(posedge clk or negedge fabric_nrst[0])
    if (!fabric_nrst[0]) q1 <= 1'b0;
    else q1 <= cfg1[sel];
  assign le_out = cfg1[16] ? q1 : cfg1[sel];

  function automatic int total(input int idx);
    return (idx != 0) ? 68 : 17;
  endfunction

  function automatic int bcnt(input int idx);
    return (idx != 0) ? int'(bc4) : int'(bc1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) if (in_valid[k] && in_ready[k]) hs_cnt[k]++;
  end

  task automatic mon(input int idx);
    bit e;
    if (config_en[idx]) begin
      en_cnt[idx]++;
      last_en[idx] = cyc;
      if (((idx != 0) ? sb1.size() : sb0.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra_bit inst %0d: got shift of %b expected no shift", idx, config_data[idx]);
      end else begin
        e = (idx != 0) ? sb1.pop_front() : sb0.pop_front();
        chk("stream_bit", 32'(config_data[idx]), 32'(e));
      end
    end else begin
      chk("idle_data_zero", 32'(config_data[idx]), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic send_word(input int idx, input logic [7:0] w, input int stall);
    bit got = 0;
    int n;
    in_data[idx]  = w;
    in_valid[idx] = (stall == 0);
    for (int t = 0; t < 100; t++) begin
      if (in_ready[idx]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("fetch_timeout", 32'(got), 32'(1));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_no_shift", 32'({config_en[idx], in_ready[idx]}), 32'(2'b01));
    end
    in_valid[idx] = 1'b1;
    n = total(idx) - pushed[idx];
    if (n > 8) n = 8;
    for (int b = 7; b >= 8 - n; b--)
      if (idx != 0) sb1.push_back(w[b]);
      else sb0.push_back(w[b]);
    pushed[idx] += n;
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  task automatic start_load(input int idx);
    en_cnt[idx] = 0;
    hs_cnt[idx] = 0;
    pushed[idx] = 0;
    if (idx != 0) sb1.delete();
    else sb0.delete();
    start[idx] = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start[idx] = 1'b0;
    chk("start_state", 32'({busy[idx], in_ready[idx], done[idx], err[idx], fabric_nrst[idx]}),
        32'(5'b11000));
    chk("start_bit_cnt", 32'(bcnt(idx)), 32'(0));
  endtask

  task automatic finish_load(input int idx, input int extra);
    bit   got = 0;
    logic prev_rst = 1'b1;
    int   tot = total(idx);
    int   nw  = (tot + 7) / 8;
    for (int t = 0; t < 400; t++) begin
      if (done[idx]) begin
        got = 1;
        break;
      end
      prev_rst = fabric_nrst[idx];
      @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'(1));
    chk("done_state", 32'({fabric_nrst[idx], busy[idx], err[idx], prev_rst}), 32'(4'b1000));
    chk("final_bit_cnt", 32'(bcnt(idx)), 32'(tot));
    chk("en_cycles", 32'(en_cnt[idx]), 32'(tot));
    chk("handshakes", 32'(hs_cnt[idx]), 32'(nw));
    chk("settle_latency", 32'(cyc - last_en[idx]), 32'(RST + 1));
    chk("load_time", 32'(cyc - start_cyc), 32'(tot + nw + RST + 1 + extra));
    chk("sb_drained", 32'((idx != 0) ? sb1.size() : sb0.size()), 32'(0));
  endtask

  task automatic full_load(input int idx, input int stall_at, input int stall_len);
    int nw = (total(idx) + 7) / 8;
    start_load(idx);
    for (int i = 0; i < nw; i++) send_word(idx, wbuf[i], (i == stall_at) ? stall_len : 0);
    finish_load(idx, (stall_at >= 0) ? stall_len : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic prev;
    logic [3:0] sv;
    int b;
    bit got;

    vt[0] = '{24'h34CB00, 17'h06996, 1'b1};
    vt[1] = '{24'h800080, 17'h10001, 1'b0};
    vt[2] = '{24'hA55AFF, 17'h14AB5, 1'b0};
    vt[3] = '{24'h34CB7F, 17'h06996, 1'b1};

    start = '0;
    abort = '0;
    in_valid = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    sel = '0;
    for (int k = 0; k < 2; k++) begin
      en_cnt[k] = 0;
      last_en[k] = 0;
      hs_cnt[k] = 0;
      pushed[k] = 0;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", 32'({in_ready[k], config_en[k], config_data[k], fabric_nrst[k],
                                busy[k], done[k], err[k]}), 32'(0));
    chk("reset_bit_cnt", 32'({bc1, bc4}), 32'(0));
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      wbuf[0] = vt[i].words[23:16];
      wbuf[1] = vt[i].words[15:8];
      wbuf[2] = vt[i].words[7:0];
      full_load(0, -1, 0);
      chk("cfg_image", 32'(cfg1), 32'(vt[i].cfg));
      if (!vt[i].cfg[16]) begin
        for (int s = 0; s < 16; s++) begin
          sv = s[3:0];
          sel = sv;
          #1;
          chk("le_comb", 32'(le_out), 32'(vt[i].cfg[s]));
          if (vt[i].parity) chk("le_xor", 32'(le_out), 32'(^sv));
          @(negedge clk);
        end
      end else begin
        sel = 4'hF;
        repeat (2) @(negedge clk);
        prev = vt[i].cfg[15];
        for (int s = 0; s < 16; s++) begin
          sel = s[3:0];
          #1;
          chk("le_reg_hold", 32'(le_out), 32'(prev));
          @(posedge clk);
          #1;
          chk("le_reg_update", 32'(le_out), 32'(vt[i].cfg[s]));
          prev = vt[i].cfg[s];
          @(negedge clk);
        end
      end
    end

    for (int i = 0; i < 9; i++) wbuf[i] = 8'($urandom);
    full_load(1, -1, 0);
    for (int i = 0; i < 9; i++) wbuf[i] = 8'($urandom);
    full_load(1, 3, 5);

    start_load(1);
    send_word(1, 8'hC3, 0);
    repeat (2) @(negedge clk);
    b = bcnt(1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    chk("start_in_shift_ignored", 32'(bcnt(1)), 32'(b + 1));
    chk("start_in_shift_busy", 32'({busy[1], config_en[1]}), 32'(2'b11));
    send_word(1, 8'h5A, 0);
    send_word(1, 8'h0F, 0);
    got = 0;
    for (int t = 0; t < 20; t++) begin
      if (bcnt(1) == 20) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_20_bits", 32'(got), 32'(1));
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    chk("abort_flags", 32'({config_en[1], in_ready[1], busy[1], done[1], err[1], fabric_nrst[1]}),
        32'(6'b000010));
    chk("abort_bit_cnt", 32'(bcnt(1)), 32'(20));
    sb1.delete();
    repeat (2) @(negedge clk);
    chk("abort_cnt_frozen", 32'({bcnt(1), busy[1], in_ready[1]}), 32'({32'd20, 2'b00}));

    for (int i = 0; i < 9; i++) wbuf[i] = 8'($urandom);
    full_load(1, -1, 0);

    start_load(1);
    send_word(1, 8'hFF, 0);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({in_ready[1], config_en[1], config_data[1], fabric_nrst[1],
                                    busy[1], done[1], err[1]}), 32'(0));
    chk("async_reset_bit_cnt", 32'(bc4), 32'(0));
    @(negedge clk);
    sb1.delete();
    nrst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({busy[1], in_ready[1], config_en[1], fabric_nrst[1]}), 32'(0));
    end

    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    abort[1] = 1'b0;
    chk("start_abort_idle", 32'({busy[1], in_ready[1], config_en[1], done[1], err[1]}),
        32'(5'b00001));
    @(negedge clk);
    chk("start_abort_stays", 32'({busy[1], in_ready[1]}), 32'(0));

    for (int i = 0; i < 9; i++) wbuf[i] = 8'($urandom);
    full_load(1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
